spio_spinnaker_link_synchronous_receiver: RTL and testbench

- Receives SpiNNaker packets from an asynchronous, self-timed 2-of-7 NRZ link and acknowledges each flit by toggling an NRZ ACK.
- Decodes 4-bit symbols and EOP, reassembles 40- or 72-bit packets, and presents them on a valid/ready packet interface.
- Reports flit, framing and glitch errors.
- Sits between the board's SpiNNaker link pins and the on-chip packet fabric.

---
 rtl/spio_spinnaker_link_synchronous_receiver.sv | 179 +++++++++++++++++
 tb/tb_spio_spinnaker_link_synchronous_receiver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_synchronous_receiver.sv
// SpiNNaker 2-of-7 NRZ link receiver: synchronises the wires, decodes flits,
// assembles 40/72-bit packets. Optional macro SPIO_SL_RX_STICKY_ERR_EN makes error outputs sticky.
module spio_spinnaker_link_synchronous_receiver (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [6:0]  SL_DATA_2OF7_IN,
  output logic        SL_ACK_OUT,
  output logic        FLT_ERR_OUT,
  output logic        FRM_ERR_OUT,
  output logic        GCH_ERR_OUT,
  output logic [71:0] PKT_DATA_OUT,
  output logic        PKT_VLD_OUT,
  input  logic        PKT_RDY_IN
);

  logic [6:0]  sync1_q, sync2_q, stab_q, ref_q, ref_d;
  logic [1:0]  st_q, st_d;
  logic        ack_q, ack_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d, ovf_q, ovf_d;
  logic [71:0] buf_q, buf_d, pkt_q, pkt_d;
  logic        vld_q, vld_d;
  logic        flt_q, flt_d, frm_q, frm_d, gch_q, gch_d;
  logic        flt_evt, frm_evt, gch_evt;

  logic [6:0]  diff;
  logic [2:0]  pc;
  logic        started, stable, flit, full, stall, consume, len_ok;
  logic        code_ok, is_eop;
  logic [3:0]  sym;

  function automatic logic [2:0] popcnt7(input logic [6:0] v);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 7; i++) s = s + {2'b00, v[i]};
    return s;
  endfunction

  assign started = (st_q == 2'd2);
  assign stable  = started && (sync2_q == stab_q);
  assign diff    = stab_q ^ ref_q;
  assign pc      = popcnt7(diff);
  assign flit    = stable && (pc >= 3'd2);
  assign full    = vld_q && !PKT_RDY_IN;
  // An EOP that would overwrite an undelivered packet is left unacknowledged.
  assign stall   = flit && (pc == 3'd2) && code_ok && is_eop && full;
  assign consume = flit && !stall;
  assign len_ok  = buf_q[1] ? (cnt_q == 5'd18) : (cnt_q == 5'd10);

  always_comb begin
    code_ok = 1'b1;
    is_eop  = 1'b0;
    sym     = 4'd0;
    case (diff)
      7'b0010001: sym = 4'd0;
      7'b0010010: sym = 4'd1;
      7'b0010100: sym = 4'd2;
      7'b0011000: sym = 4'd3;
      7'b0100001: sym = 4'd4;
      7'b0100010: sym = 4'd5;
      7'b0100100: sym = 4'd6;
      7'b0101000: sym = 4'd7;
      7'b1000001: sym = 4'd8;
      7'b1000010: sym = 4'd9;
      7'b1000100: sym = 4'd10;
      7'b1001000: sym = 4'd11;
      7'b0000011: sym = 4'd12;
      7'b0000110: sym = 4'd13;
      7'b0001100: sym = 4'd14;
      7'b0001001: sym = 4'd15;
      7'b1100000: is_eop = 1'b1;
      default:    code_ok = 1'b0;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    ack_d   = ack_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    ovf_d   = ovf_q;
    buf_d   = buf_q;
    pkt_d   = pkt_q;
    vld_d   = vld_q;
    flt_evt = 1'b0;
    frm_evt = 1'b0;
    gch_evt = 1'b0;

    if (!started) st_d = st_q + 2'd1;
    if (st_q == 2'd1) ack_d = 1'b1;

    if (vld_q && PKT_RDY_IN) vld_d = 1'b0;

    if (consume) begin
      ack_d = ~ack_q;
      ref_d = stab_q;
      if (pc != 3'd2) begin
        gch_evt = 1'b1;
        bad_d   = 1'b1;
      end else if (!code_ok) begin
        flt_evt = 1'b1;
        bad_d   = 1'b1;
      end else if (is_eop) begin
        if (cnt_q != 5'd0) begin
          if (!len_ok && !ovf_q) frm_evt = 1'b1;
          if (len_ok && !bad_q && !ovf_q) begin
            // Stale payload from an earlier long packet must not leak out.
            pkt_d = {buf_q[1] ? buf_q[71:40] : 32'h0, buf_q[39:0]};
            vld_d = 1'b1;
          end
        end
        cnt_d = '0;
        bad_d = 1'b0;
        ovf_d = 1'b0;
      end else if (cnt_q < 5'd18) begin
        buf_d[{cnt_q, 2'b00} +: 4] = sym;
        cnt_d = cnt_q + 5'd1;
      end else if (!ovf_q) begin
        frm_evt = 1'b1;
        ovf_d   = 1'b1;
      end
    end

`ifdef SPIO_SL_RX_STICKY_ERR_EN
    flt_d = flt_q | flt_evt;
    frm_d = frm_q | frm_evt;
    gch_d = gch_q | gch_evt;
`else
    flt_d = flt_evt;
    frm_d = frm_evt;
    gch_d = gch_evt;
`endif
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stab_q  <= '0;
      ref_q   <= '0;
      st_q    <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      ovf_q   <= 1'b0;
      buf_q   <= '0;
      pkt_q   <= '0;
      vld_q   <= 1'b0;
      flt_q   <= 1'b0;
      frm_q   <= 1'b0;
      gch_q   <= 1'b0;
    end else begin
      sync1_q <= SL_DATA_2OF7_IN;
      sync2_q <= sync1_q;
      stab_q  <= sync2_q;
      ref_q   <= ref_d;
      st_q    <= st_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      ovf_q   <= ovf_d;
      buf_q   <= buf_d;
      pkt_q   <= pkt_d;
      vld_q   <= vld_d;
      flt_q   <= flt_d;
      frm_q   <= frm_d;
      gch_q   <= gch_d;
    end
  end

  assign SL_ACK_OUT   = ack_q;
  assign PKT_DATA_OUT = pkt_q;
  assign PKT_VLD_OUT  = vld_q;
  assign FLT_ERR_OUT  = flt_q;
  assign FRM_ERR_OUT  = frm_q;
  assign GCH_ERR_OUT  = gch_q;

endmodule

// File: tb/tb_spio_spinnaker_link_synchronous_receiver.sv
// Directed bench for the 2-of-7 link receiver: drives NRZ flits, scoreboards delivered packets.
module tb_spio_spinnaker_link_synchronous_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  sl_data;
  logic        sl_ack, flt_err, frm_err, gch_err, pkt_vld, pkt_rdy;
  logic [71:0] pkt_data;

  spio_spinnaker_link_synchronous_receiver dut (
    .CLK_IN(clk), .RESET_IN(rst_n), .SL_DATA_2OF7_IN(sl_data), .SL_ACK_OUT(sl_ack),
    .FLT_ERR_OUT(flt_err), .FRM_ERR_OUT(frm_err), .GCH_ERR_OUT(gch_err),
    .PKT_DATA_OUT(pkt_data), .PKT_VLD_OUT(pkt_vld), .PKT_RDY_IN(pkt_rdy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int flt_n = 0, frm_n = 0, gch_n = 0, ack_tog = 0, delivered = 0;
  logic ack_prev = 1'b0;
  logic ack_exp  = 1'b0;
  logic [71:0] exp_q[$];

  logic [6:0] sym_code [0:15] = '{7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
                                  7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
                                  7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
                                  7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001};
  localparam logic [6:0] EOP = 7'b1100000;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor samples on the falling edge; stimulus changes just after the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flt_err) flt_n++;
      if (frm_err) frm_n++;
      if (gch_err) gch_n++;
      if (sl_ack !== ack_prev) ack_tog++;
      ack_prev = sl_ack;
      if (pkt_vld && pkt_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_vld", pkt_data, 72'hx);
        else chk("pkt_data", pkt_data, exp_q.pop_front());
        delivered++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_code(input logic [6:0] code, input logic [6:0] extra, input string tag);
    int n;
    ack_exp = ~ack_exp;
    sl_data = sl_data ^ code;
    if (extra != 7'd0) begin tick(); sl_data = sl_data ^ extra; end
    n = 0;
    while (sl_ack !== ack_exp && n < 100) begin tick(); n++; end
    chk(tag, {71'd0, sl_ack}, {71'd0, ack_exp});
  endtask

  task automatic send_nibs(input logic [71:0] p, input int first, input int last);
    for (int i = first; i < last; i++) send_code(sym_code[p[4*(i%18) +: 4]], 7'd0, "ack_nib");
  endtask

  function automatic logic [71:0] expect_of(input logic [71:0] p);
    return {p[1] ? p[71:40] : 32'h0, p[39:0]};
  endfunction

  task automatic send_pkt(input logic [71:0] p);
    exp_q.push_back(expect_of(p));
    send_nibs(p, 0, p[1] ? 18 : 10);
    send_code(EOP, 7'd0, "ack_eop");
  endtask

  logic [71:0] p1, p2, p3;
  int a0, f0, r0, g0, d0;

  initial begin
    rst_n = 1'b0; sl_data = '0; pkt_rdy = 1'b1;
    tick(3);
    chk("rst_ack", {71'd0, sl_ack}, 72'd0);
    chk("rst_vld", {71'd0, pkt_vld}, 72'd0);
    chk("rst_data", pkt_data, 72'd0);
    chk("rst_err", {69'd0, flt_err, frm_err, gch_err}, 72'd0);
    rst_n = 1'b1;
    tick(2);
    ack_exp = 1'b1;
    chk("startup_ack", {71'd0, sl_ack}, 72'd1);
    chk("startup_vld_err", {68'd0, pkt_vld, flt_err, frm_err, gch_err}, 72'd0);
    tick(2);

    // 40-bit packet, expected value written out in full
    a0 = ack_tog;
    exp_q.push_back(72'h00_0000_0000_0000_0101);
    send_nibs({32'h0, 32'h1, 8'h01}, 0, 10);
    send_code(EOP, 7'd0, "ack_eop");
    tick(10);
    chk("short_ack_toggles", 72'(ack_tog - a0), 72'd11);
    chk("short_delivered", 72'(delivered), 72'd1);

    // 72-bit packet
    send_pkt({32'hA5A5A5B3, 32'h0000000F, 8'h02});
    tick(10);
    chk("long_delivered", 72'(delivered), 72'd2);
    chk("no_errs", 72'(flt_n + frm_n + gch_n), 72'd0);

    // back-pressure: second EOP must be withheld while the first packet waits
    pkt_rdy = 1'b0;
    p1 = {32'h0, 32'hDEADBEEF, 8'h10};
    p2 = {32'h13572468, 32'hCAFEF00D, 8'h06};
    p3 = {32'hFFFF0000, 32'h12345678, 8'h04};
    send_pkt(p1);
    exp_q.push_back(expect_of(p2));
    send_nibs(p2, 0, 18);
    ack_exp = ~ack_exp;
    sl_data = sl_data ^ EOP;
    tick(150);
    chk("bp_ack_withheld", {71'd0, sl_ack}, {71'd0, ~ack_exp});
    chk("bp_vld_held", {71'd0, pkt_vld}, 72'd1);
    chk("bp_data_held", pkt_data, expect_of(p1));
    chk("bp_none_delivered", 72'(delivered), 72'd2);
    pkt_rdy = 1'b1;
    a0 = 0;
    while (sl_ack !== ack_exp && a0 < 100) begin tick(); a0++; end
    chk("bp_ack_released", {71'd0, sl_ack}, {71'd0, ack_exp});
    send_pkt(p3);
    tick(10);
    chk("bp_delivered", 72'(delivered), 72'd5);

    // glitch: third wire arrives one cycle after the first two
    g0 = gch_n; d0 = delivered;
    send_nibs(p1, 0, 5);
    send_code(7'b0010010, 7'b0001000, "ack_glitch");
    send_nibs(p1, 5, 10);
    send_code(EOP, 7'd0, "ack_eop");
    tick(5);
    chk("gch_pulse", 72'(gch_n - g0), 72'd1);
    chk("gch_dropped", 72'(delivered - d0), 72'd0);
    send_pkt(p2);
    tick(10);
    chk("gch_next_ok", 72'(delivered - d0), 72'd1);

    // invalid code
    f0 = flt_n; d0 = delivered;
    send_nibs(p1, 0, 5);
    send_code(7'b0110000, 7'd0, "ack_flt");
    send_nibs(p1, 5, 10);
    send_code(EOP, 7'd0, "ack_eop");
    tick(5);
    chk("flt_pulse", 72'(flt_n - f0), 72'd1);
    chk("flt_dropped", 72'(delivered - d0), 72'd0);

    // short packet, overflow, wrong length for payload flag, lone EOP
    r0 = frm_n;
    send_nibs(p1, 0, 5);
    send_code(EOP, 7'd0, "ack_eop");
    tick(5);
    chk("frm_short", 72'(frm_n - r0), 72'd1);
    send_nibs(p2, 0, 20);
    send_code(EOP, 7'd0, "ack_eop");
    tick(5);
    chk("frm_overflow_once", 72'(frm_n - r0), 72'd2);
    send_nibs(p2, 0, 10);
    send_code(EOP, 7'd0, "ack_eop");
    tick(5);
    chk("frm_flag_len", 72'(frm_n - r0), 72'd3);
    send_code(EOP, 7'd0, "ack_eop");
    tick(5);
    chk("lone_eop_silent", 72'(frm_n - r0), 72'd3);
    chk("err_dropped", 72'(delivered - d0), 72'd0);

    send_pkt(p3);
    tick(20);
    chk("final_delivered", 72'(delivered - d0), 72'd1);
    chk("queue_empty", 72'(exp_q.size()), 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
